up_down_mod_counter: RTL and testbench
======================================

Name: up_down_mod_counter

Overview:
Parametrised successor to the fixed 5-bit up counter. Counts up or down over the range 0..MAX_COUNT, with enable, synchronous parallel load, wrap or saturate mode, terminal-count flag, wrap pulse, and a sticky overflow flag. Used as a generic counting primitive in benchmark designs and as a golden model for post-route netlist comparison benches.

Parameters:
WIDTH, 5, counter width in bits (1..32)
MAX_COUNT, 2**WIDTH-1 (31), highest count value; legal range 1..2**WIDTH-1
SATURATE, 0, 0 = wrap at the range ends, 1 = hold at the range ends
RESET_VALUE, 0, value of out after reset; must be <= MAX_COUNT

Ports:
clk  input  1  clock; all state updates on the rising edge
reset  input  1  asynchronous, active-high reset
en  input  1  count enable
up_dn  input  1  direction: 1 = up, 0 = down
load  input  1  synchronous load strobe
load_val  input  WIDTH  value to load
clr_ovf  input  1  synchronous clear of ovf_sticky
out  output  WIDTH  current count, registered
tc  output  1  terminal count, combinational from out and up_dn
wrap  output  1  registered one-cycle pulse following a boundary event
ovf_sticky  output  1  sticky boundary-event flag

Behaviour:
- Reset (asynchronous, immediate on reset=1): out=RESET_VALUE, wrap=0, ovf_sticky=0. Held while reset=1. First update on the first rising edge after reset deasserts.
- Per-edge priority: reset > load > en > hold.
- load=1: out <= min(load_val, MAX_COUNT), so an out-of-range load clamps to MAX_COUNT. Load ignores en and up_dn. It generates no wrap and does not change ovf_sticky.
- en=1, load=0, up_dn=1:
  - if out < MAX_COUNT, out <= out+1
  - if out == MAX_COUNT, this is a boundary event; out <= 0 when SATURATE=0, or stays MAX_COUNT when SATURATE=1
- en=1, load=0, up_dn=0:
  - if out > 0, out <= out-1
  - if out == 0, this is a boundary event; out <= MAX_COUNT when SATURATE=0, or stays 0 when SATURATE=1
- en=0, load=0: out holds.
- Arithmetic: do the compare before the increment or decrement. out never leaves 0..MAX_COUNT. No carry is exposed.
- tc = (up_dn && out==MAX_COUNT) || (!up_dn && out==0). It is combinational, so changing direction updates tc in the same cycle.
- wrap: registered. Equals 1 for exactly the one cycle after an edge on which a boundary event occurred, otherwise 0. Back-to-back boundary events give wrap high on consecutive cycles. This holds for WIDTH=1, MAX_COUNT=1, and for a saturated hold with en held high.
- ovf_sticky: set on the edge of any boundary event, cleared on an edge with clr_ovf=1. If both happen on the same edge, set wins. Otherwise it holds.
- Reset mid-count, asserted asynchronously between edges: out returns to RESET_VALUE immediately, and any pending wrap is dropped.
- Default configuration (WIDTH=5, MAX_COUNT=31, SATURATE=0, RESET_VALUE=0, en=1, up_dn=1, load=0, clr_ovf=0) reproduces the legacy 5-bit up counter cycle for cycle.

Test Plan:
- Legacy equivalence: default parameters, en=1, up_dn=1, reset for 2 cycles then released for 50 cycles, then reset for 5 and released for 50 -> out matches 0,1,..,31,0,.. every cycle; wrap pulses 1 cycle after each 31->0; ovf_sticky=1 after the first wrap.
- Modulo and down-count: MAX_COUNT=9, up_dn=0 from out=2 -> out 1,0,9,8; tc=1 while out=0; wrap=1 the cycle after 0->9; tc=1 at out=9 once up_dn switches to 1.
- Saturation: SATURATE=1, MAX_COUNT=9, counting up from 7 for 5 cycles -> out 8,9,9,9,9; wrap high on each cycle after the holds at 9; ovf_sticky=1. Switch to up_dn=0 -> out 8,7.
- Load priority and clamp: MAX_COUNT=9; load=1, en=1, load_val=25 -> out=9, wrap=0, ovf_sticky unchanged; load_val=4 -> out=4.
- Sticky clear collision: an edge with both a boundary event and clr_ovf=1 -> ovf_sticky stays 1; the next edge with clr_ovf=1 and no event -> ovf_sticky=0.
- Asynchronous reset mid-operation: RESET_VALUE=3, reset pulsed between edges while out=17 -> out=3, wrap=0, ovf_sticky=0 without waiting for a clock edge; counting resumes at 4 after release.

Source files
------------

// File: rtl/up_down_mod_counter.sv
`default_nettype none
// ============================================================================
//  Module      : up_down_mod_counter
//  Description : Parametrised up/down modulo counter with enable, synchronous
//                clamped load, wrap or saturate mode at the range ends,
//                combinational terminal count, registered wrap pulse and a
//                sticky boundary-event flag.
//  Revision    : 1.0 - initial release
// ============================================================================
module up_down_mod_counter #(
    parameter int          WIDTH       = 5,
    parameter int unsigned MAX_COUNT   = 32'((64'd1 << WIDTH) - 64'd1),
    parameter bit          SATURATE    = 1'b0,
    parameter int unsigned RESET_VALUE = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             up_dn,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             clr_ovf,
    output logic [WIDTH-1:0] out,
    output logic             tc,
    output logic             wrap,
    output logic             ovf_sticky
);

    localparam logic [WIDTH-1:0] c_MAX_COUNT   = WIDTH'(MAX_COUNT);
    localparam logic [WIDTH-1:0] c_RESET_VALUE = WIDTH'(RESET_VALUE);
    localparam logic [WIDTH-1:0] c_ZERO        = '0;

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;
    logic             wrap_q;
    logic             wrap_d;
    logic             ovf_q;
    logic             ovf_d;

    logic             w_at_max;
    logic             w_at_zero;
    logic             w_event;
    logic [WIDTH-1:0] w_up_limit_val;
    logic [WIDTH-1:0] w_dn_limit_val;
    logic [WIDTH-1:0] w_load_clamped;

    // Range-end comparisons are taken on the current count, before any
    // increment or decrement, so the count can never leave 0..MAX_COUNT.
    assign w_at_max  = (count_q == c_MAX_COUNT);
    assign w_at_zero = (count_q == c_ZERO);

    // Out-of-range load values clamp to the top of the range.
    assign w_load_clamped = (load_val > c_MAX_COUNT) ? c_MAX_COUNT : load_val;

    // Value taken when a boundary event occurs: hold in saturate mode,
    // jump to the opposite end in wrap mode.
    if (SATURATE) begin : g_saturate
        assign w_up_limit_val = c_MAX_COUNT;
        assign w_dn_limit_val = c_ZERO;
    end else begin : g_wrap
        assign w_up_limit_val = c_ZERO;
        assign w_dn_limit_val = c_MAX_COUNT;
    end

    // Next-state selection: load beats count enable, which beats hold.
    always_comb begin
        count_d = count_q;
        w_event = 1'b0;
        if (load) begin
            count_d = w_load_clamped;
        end else if (en) begin
            if (up_dn) begin
                if (w_at_max) begin
                    w_event = 1'b1;
                    count_d = w_up_limit_val;
                end else begin
                    count_d = count_q + 1'b1;
                end
            end else begin
                if (w_at_zero) begin
                    w_event = 1'b1;
                    count_d = w_dn_limit_val;
                end else begin
                    count_d = count_q - 1'b1;
                end
            end
        end
    end

    // Wrap pulse mirrors this edge's event; the sticky flag lets a new event
    // win over a simultaneous clear.
    always_comb begin
        wrap_d = w_event;
        ovf_d  = ovf_q;
        if (clr_ovf) begin
            ovf_d = 1'b0;
        end
        if (w_event) begin
            ovf_d = 1'b1;
        end
    end

    // State registers; reset acts immediately and drops any pending wrap.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= c_RESET_VALUE;
            wrap_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            wrap_q  <= wrap_d;
            ovf_q   <= ovf_d;
        end
    end

    // Terminal count follows direction combinationally.
    assign tc         = up_dn ? w_at_max : w_at_zero;
    assign out        = count_q;
    assign wrap       = wrap_q;
    assign ovf_sticky = ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_up_down_mod_counter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_up_down_mod_counter
//  Description : Directed self-checking bench for up_down_mod_counter using
//                several parameterisations driven from shared stimulus.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_up_down_mod_counter;

    logic       clk;
    logic       reset;
    logic       en;
    logic       up_dn;
    logic       load;
    logic [4:0] load_val;
    logic       clr_ovf;

    int checks;
    int failures;

    // A: default legacy configuration
    logic [4:0] out_a;
    logic       tc_a, wrap_a, ovf_a;
    // B: MAX_COUNT=9, wrap mode
    logic [4:0] out_b;
    logic       tc_b, wrap_b, ovf_b;
    // C: MAX_COUNT=9, saturate mode
    logic [4:0] out_c;
    logic       tc_c, wrap_c, ovf_c;
    // D: RESET_VALUE=3, full 5-bit range
    logic [4:0] out_d;
    logic       tc_d, wrap_d, ovf_d;
    // E: WIDTH=1, MAX_COUNT=1, saturate mode
    logic [0:0] out_e;
    logic       tc_e, wrap_e, ovf_e;
    logic [0:0] load_val_e;

    assign load_val_e = load_val[0:0];

    up_down_mod_counter u_a (
        .clk(clk), .reset(reset), .en(en), .up_dn(up_dn), .load(load),
        .load_val(load_val), .clr_ovf(clr_ovf),
        .out(out_a), .tc(tc_a), .wrap(wrap_a), .ovf_sticky(ovf_a)
    );

    up_down_mod_counter #(.WIDTH(5), .MAX_COUNT(9), .SATURATE(1'b0), .RESET_VALUE(0)) u_b (
        .clk(clk), .reset(reset), .en(en), .up_dn(up_dn), .load(load),
        .load_val(load_val), .clr_ovf(clr_ovf),
        .out(out_b), .tc(tc_b), .wrap(wrap_b), .ovf_sticky(ovf_b)
    );

    up_down_mod_counter #(.WIDTH(5), .MAX_COUNT(9), .SATURATE(1'b1), .RESET_VALUE(0)) u_c (
        .clk(clk), .reset(reset), .en(en), .up_dn(up_dn), .load(load),
        .load_val(load_val), .clr_ovf(clr_ovf),
        .out(out_c), .tc(tc_c), .wrap(wrap_c), .ovf_sticky(ovf_c)
    );

    up_down_mod_counter #(.WIDTH(5), .MAX_COUNT(31), .SATURATE(1'b0), .RESET_VALUE(3)) u_d (
        .clk(clk), .reset(reset), .en(en), .up_dn(up_dn), .load(load),
        .load_val(load_val), .clr_ovf(clr_ovf),
        .out(out_d), .tc(tc_d), .wrap(wrap_d), .ovf_sticky(ovf_d)
    );

    up_down_mod_counter #(.WIDTH(1), .MAX_COUNT(1), .SATURATE(1'b1), .RESET_VALUE(0)) u_e (
        .clk(clk), .reset(reset), .en(en), .up_dn(up_dn), .load(load),
        .load_val(load_val_e), .clr_ovf(clr_ovf),
        .out(out_e), .tc(tc_e), .wrap(wrap_e), .ovf_sticky(ovf_e)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset    = 1'b1;
        en       = 1'b0;
        up_dn    = 1'b1;
        load     = 1'b0;
        load_val = 5'd0;
        clr_ovf  = 1'b0;
        step();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; en = 1'b1; up_dn = 1'b1; load = 1'b0; load_val = 5'd0; clr_ovf = 1'b0;
        #1;
        checks++; if (out_a !== 5'd0) begin failures++; $display("FAIL reset_out_a got=%0d exp=0", out_a); end
        checks++; if (out_d !== 5'd3) begin failures++; $display("FAIL reset_out_d got=%0d exp=3", out_d); end
        checks++; if (wrap_a !== 1'b0 || ovf_a !== 1'b0) begin failures++; $display("FAIL reset_flags_a wrap=%0b ovf=%0b exp=0,0", wrap_a, ovf_a); end
    endtask

    task automatic legacy_run();
        for (int i = 1; i <= 50; i++) begin
            step();
            checks++;
            if (out_a !== 5'(i % 32)) begin failures++; $display("FAIL legacy_out cyc=%0d got=%0d exp=%0d", i, out_a, i % 32); end
            checks++;
            if (wrap_a !== (i == 32)) begin failures++; $display("FAIL legacy_wrap cyc=%0d got=%0b exp=%0b", i, wrap_a, (i == 32)); end
            checks++;
            if (ovf_a !== (i >= 32)) begin failures++; $display("FAIL legacy_ovf cyc=%0d got=%0b exp=%0b", i, ovf_a, (i >= 32)); end
        end
    endtask

    task automatic test_legacy();
        reset = 1'b1; en = 1'b1; up_dn = 1'b1; load = 1'b0; clr_ovf = 1'b0;
        for (int i = 0; i < 2; i++) begin
            step();
            checks++; if (out_a !== 5'd0 || wrap_a !== 1'b0) begin failures++; $display("FAIL legacy_rst1 out=%0d wrap=%0b exp=0,0", out_a, wrap_a); end
        end
        reset = 1'b0;
        legacy_run();
        reset = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            checks++; if (out_a !== 5'd0 || wrap_a !== 1'b0 || ovf_a !== 1'b0) begin failures++; $display("FAIL legacy_rst2 out=%0d wrap=%0b ovf=%0b exp=0,0,0", out_a, wrap_a, ovf_a); end
        end
        reset = 1'b0;
        legacy_run();
    endtask

    task automatic test_modulo_down();
        do_reset();
        load = 1'b1; load_val = 5'd2; step(); load = 1'b0;
        checks++; if (out_b !== 5'd2) begin failures++; $display("FAIL mod_load out=%0d exp=2", out_b); end
        en = 1'b1; up_dn = 1'b0;
        step();
        checks++; if (out_b !== 5'd1 || tc_b !== 1'b0) begin failures++; $display("FAIL mod_dn1 out=%0d tc=%0b exp=1,0", out_b, tc_b); end
        step();
        checks++; if (out_b !== 5'd0 || tc_b !== 1'b1 || wrap_b !== 1'b0) begin failures++; $display("FAIL mod_dn0 out=%0d tc=%0b wrap=%0b exp=0,1,0", out_b, tc_b, wrap_b); end
        step();
        checks++; if (out_b !== 5'd9 || wrap_b !== 1'b1 || ovf_b !== 1'b1 || tc_b !== 1'b0) begin failures++; $display("FAIL mod_wrap9 out=%0d wrap=%0b ovf=%0b tc=%0b exp=9,1,1,0", out_b, wrap_b, ovf_b, tc_b); end
        up_dn = 1'b1; #1;
        checks++; if (tc_b !== 1'b1) begin failures++; $display("FAIL mod_tc_dir got=%0b exp=1", tc_b); end
        up_dn = 1'b0;
        step();
        checks++; if (out_b !== 5'd8 || wrap_b !== 1'b0) begin failures++; $display("FAIL mod_dn8 out=%0d wrap=%0b exp=8,0", out_b, wrap_b); end
        en = 1'b0;
    endtask

    task automatic test_saturate();
        int exp_o[5] = '{8, 9, 9, 9, 9};
        bit exp_w[5] = '{0, 0, 1, 1, 1};
        do_reset();
        load = 1'b1; load_val = 5'd7; step(); load = 1'b0;
        en = 1'b1; up_dn = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            checks++;
            if (out_c !== 5'(exp_o[i]) || wrap_c !== exp_w[i]) begin failures++; $display("FAIL sat_up idx=%0d out=%0d wrap=%0b exp=%0d,%0b", i, out_c, wrap_c, exp_o[i], exp_w[i]); end
        end
        checks++; if (ovf_c !== 1'b1) begin failures++; $display("FAIL sat_ovf got=%0b exp=1", ovf_c); end
        up_dn = 1'b0;
        step();
        checks++; if (out_c !== 5'd8 || wrap_c !== 1'b0) begin failures++; $display("FAIL sat_dn8 out=%0d wrap=%0b exp=8,0", out_c, wrap_c); end
        step();
        checks++; if (out_c !== 5'd7 || ovf_c !== 1'b1) begin failures++; $display("FAIL sat_dn7 out=%0d ovf=%0b exp=7,1", out_c, ovf_c); end
        en = 1'b0;
    endtask

    task automatic test_load_priority();
        do_reset();
        en = 1'b1; up_dn = 1'b0;
        step();
        checks++; if (out_b !== 5'd9 || ovf_b !== 1'b1) begin failures++; $display("FAIL ld_pre out=%0d ovf=%0b exp=9,1", out_b, ovf_b); end
        load = 1'b1; up_dn = 1'b1; load_val = 5'd25;
        step();
        checks++; if (out_b !== 5'd9 || wrap_b !== 1'b0 || ovf_b !== 1'b1) begin failures++; $display("FAIL ld_clamp out=%0d wrap=%0b ovf=%0b exp=9,0,1", out_b, wrap_b, ovf_b); end
        checks++; if (out_c !== 5'd9) begin failures++; $display("FAIL ld_clamp_sat out=%0d exp=9", out_c); end
        checks++; if (out_a !== 5'd25 || wrap_a !== 1'b0) begin failures++; $display("FAIL ld_full out=%0d wrap=%0b exp=25,0", out_a, wrap_a); end
        load_val = 5'd4;
        step();
        checks++; if (out_b !== 5'd4 || wrap_b !== 1'b0 || ovf_b !== 1'b1) begin failures++; $display("FAIL ld_4 out=%0d wrap=%0b ovf=%0b exp=4,0,1", out_b, wrap_b, ovf_b); end
        load = 1'b0; en = 1'b0;
    endtask

    task automatic test_sticky_clear();
        do_reset();
        en = 1'b1; up_dn = 1'b0; clr_ovf = 1'b1;
        step();
        checks++; if (out_b !== 5'd9 || ovf_b !== 1'b1 || wrap_b !== 1'b1) begin failures++; $display("FAIL clr_collide out=%0d ovf=%0b wrap=%0b exp=9,1,1", out_b, ovf_b, wrap_b); end
        en = 1'b0;
        step();
        checks++; if (ovf_b !== 1'b0 || wrap_b !== 1'b0 || out_b !== 5'd9) begin failures++; $display("FAIL clr_plain ovf=%0b wrap=%0b out=%0d exp=0,0,9", ovf_b, wrap_b, out_b); end
        clr_ovf = 1'b0;
    endtask

    task automatic test_async_reset();
        do_reset();
        checks++; if (out_d !== 5'd3) begin failures++; $display("FAIL ar_init out=%0d exp=3", out_d); end
        load = 1'b1; load_val = 5'd17; step(); load = 1'b0;
        checks++; if (out_d !== 5'd17) begin failures++; $display("FAIL ar_load out=%0d exp=17", out_d); end
        #2 reset = 1'b1;
        #1;
        checks++; if (out_d !== 5'd3 || wrap_d !== 1'b0 || ovf_d !== 1'b0) begin failures++; $display("FAIL ar_mid out=%0d wrap=%0b ovf=%0b exp=3,0,0", out_d, wrap_d, ovf_d); end
        #1 reset = 1'b0;
        en = 1'b1; up_dn = 1'b1;
        step();
        checks++; if (out_d !== 5'd4) begin failures++; $display("FAIL ar_resume out=%0d exp=4", out_d); end
        load = 1'b1; load_val = 5'd31; step(); load = 1'b0;
        step();
        checks++; if (out_d !== 5'd0 || wrap_d !== 1'b1 || ovf_d !== 1'b1) begin failures++; $display("FAIL ar_prewrap out=%0d wrap=%0b ovf=%0b exp=0,1,1", out_d, wrap_d, ovf_d); end
        #2 reset = 1'b1;
        #1;
        checks++; if (out_d !== 5'd3 || wrap_d !== 1'b0 || ovf_d !== 1'b0) begin failures++; $display("FAIL ar_drop out=%0d wrap=%0b ovf=%0b exp=3,0,0", out_d, wrap_d, ovf_d); end
        #1 reset = 1'b0;
        step();
        checks++; if (out_d !== 5'd4 || wrap_d !== 1'b0) begin failures++; $display("FAIL ar_resume2 out=%0d wrap=%0b exp=4,0", out_d, wrap_d); end
        en = 1'b0;
    endtask

    task automatic test_back_to_back();
        bit exp_o[5] = '{1, 1, 1, 0, 0};
        bit exp_w[5] = '{0, 1, 1, 0, 1};
        do_reset();
        en = 1'b1; up_dn = 1'b1;
        for (int i = 0; i < 5; i++) begin
            if (i == 3) up_dn = 1'b0;
            step();
            checks++;
            if (out_e !== exp_o[i] || wrap_e !== exp_w[i]) begin failures++; $display("FAIL w1_b2b idx=%0d out=%0d wrap=%0b exp=%0d,%0b", i, out_e, wrap_e, exp_o[i], exp_w[i]); end
        end
        checks++; if (tc_e !== 1'b1 || ovf_e !== 1'b1) begin failures++; $display("FAIL w1_tc tc=%0b ovf=%0b exp=1,1", tc_e, ovf_e); end
        en = 1'b0;
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        test_reset();
        test_legacy();
        test_modulo_down();
        test_saturate();
        test_load_priority();
        test_sticky_clear();
        test_async_reset();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
